// File: rtl/mem_rr_arbiter_pkg.sv
// mem_rr_arbiter_pkg: shared FSM encodings and timeout counter width for the memory arbiter
package mem_rr_arbiter_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam int TO_W = 8;
endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side signals of the arbiter
//   req_*     per-requester request handshake, addr/wdata flattened [i*W +: W]
//   rsp_*     one-hot response strobe with shared error flag and read data
//   mem_*     single downstream valid/ready request plus rvalid/rdata response
//   master    modport seen by the arbiter, slave modport seen by its environment
interface mem_rr_arbiter_if #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_wen;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic                       rsp_err;
    logic [DATA_WIDTH-1:0]      rsp_rdata;
    logic                       mem_valid;
    logic                       mem_ready;
    logic                       mem_wen;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_rvalid;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata
    );
    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// mem_rr_arbiter_rr_pick: rotate-priority encoder, first set req bit at or after ptr
//   req   in   request vector
//   ptr   in   highest-priority index
//   grant out  one-hot winner (zero when no request)
//   idx   out  winner index
//   any   out  at least one request present
module mem_rr_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // Scanning from the farthest offset down lets the nearest requester overwrite last
    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
        any = |req;
        grant = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one memory port among NREQ requesters
//   sys_clk    in   rising-edge clock
//   sys_rst_n  in   asynchronous active-low reset, aborts any transaction
//   bus        master side of mem_rr_arbiter_if (requests, responses, memory port)
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic sys_clk,
    input logic sys_rst_n,
    mem_rr_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [1:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win;
    logic            any;
    logic [TO_W-1:0] cnt;
    logic            timeout;
    mem_rr_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (win),
        .idx   (win_idx),
        .any   (any)
    );
    assign bus.req_ready = (state == ST_IDLE) ? win : '0;
    // Derived from the state register so it falls as soon as reset clears the state
    assign bus.mem_valid = (state == ST_ISSUE);
    // cnt holds the number of completed WAIT cycles, so this is the TIMEOUT-th one
    assign timeout = (cnt == TO_W'(TIMEOUT - 1));
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            cnt           <= '0;
            bus.mem_wen   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= '0;
            if (state == ST_IDLE && any) begin
                owner         <= win_idx;
                bus.mem_wen   <= bus.req_wen[win_idx];
                bus.mem_addr  <= bus.req_addr[int'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                bus.mem_wdata <= bus.req_wdata[int'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                rr_ptr        <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                state         <= ST_ISSUE;
            end
            if (state == ST_ISSUE && bus.mem_ready) begin
                cnt   <= '0;
                state <= ST_WAIT;
            end
            if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
                // A response arriving on the timeout cycle still counts as a good response
                if (bus.mem_rvalid || timeout) begin
                    bus.rsp_valid <= NREQ'(1) << owner;
                    bus.rsp_err   <= !bus.mem_rvalid;
                    bus.rsp_rdata <= bus.mem_rvalid ? bus.mem_rdata : '0;
                    state         <= ST_IDLE;
                end
            end
        end
    end
endmodule
